// File: rtl/uart_tx_line_buf_pkg.sv
// Shared definitions for the UART line buffer.
// Holds the FSM encoding, the line terminator bytes and the default capacity.
package uart_tx_line_buf_pkg;

    typedef enum logic [2:0] {
        FILL    = 3'd0,
        SEND    = 3'd1,
        GAP     = 3'd2,
        SEND_CR = 3'd3,
        GAP_CR  = 3'd4,
        SEND_LF = 3'd5,
        GAP_LF  = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam int         DEFAULT_DEPTH = 32;

endpackage

// File: rtl/uart_tx_line_buf_mem.sv
// Byte storage for the line buffer: one synchronous write port, one
// combinational read port, no reset on the array.
module line_buf_mem
    import uart_tx_line_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_r [DEPTH];

    // Write port: stores one byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_line_buf.sv
// Collects cipher bytes into a line and, on request, drains them to the UART
// transmitter followed by CR and LF.
module uart_tx_line_buf
    import uart_tx_line_buf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_rdy,
    input  logic        print_buf,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [AW:0] buf_count,
    output logic        overflow,
    output logic        draining
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t        state_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic          draining_r;
    logic          wr_en_s;
    logic [7:0]    rd_data_s;
    logic          tx_start_s;
    logic [7:0]    tx_data_s;

    assign wr_en_s = !rst && (state_r == FILL) && in_rdy && (count_r != FULL_COUNT);

    line_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (in_data),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Control FSM: pointers, occupancy, sticky overflow and drain sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= FILL;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            draining_r <= 1'b0;
        end else begin
            if (in_rdy && (state_r != FILL)) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                FILL: begin
                    if (in_rdy) begin
                        if (count_r != FULL_COUNT) begin
                            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                            count_r  <= count_r + (AW+1)'(1'b1);
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end
                    // A byte arriving with the flush request joins the line.
                    if (print_buf) begin
                        draining_r <= 1'b1;
                        state_r    <= ((count_r != '0) || in_rdy) ? SEND : SEND_CR;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                        count_r  <= count_r - (AW+1)'(1'b1);
                        state_r  <= GAP;
                    end
                end
                GAP:     state_r <= (count_r != '0) ? SEND : SEND_CR;
                SEND_CR: if (!tx_busy) state_r <= GAP_CR;
                GAP_CR:  state_r <= SEND_LF;
                SEND_LF: if (!tx_busy) state_r <= GAP_LF;
                GAP_LF: begin
                    state_r    <= FILL;
                    overflow_r <= 1'b0;
                    draining_r <= 1'b0;
                end
                default: begin
                    state_r    <= FILL;
                    draining_r <= 1'b0;
                end
            endcase
        end
    end

    // Transmit strobe: must react to tx_busy in the same cycle, so it is
    // decoded from the state register rather than delayed by a flop.
    always_comb begin
        tx_start_s = 1'b0;
        tx_data_s  = 8'h00;
        case (state_r)
            SEND: begin
                if (!tx_busy) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = rd_data_s;
                end else begin
                    tx_start_s = 1'b0;
                end
            end
            SEND_CR: begin
                if (!tx_busy) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = ASCII_CR;
                end else begin
                    tx_start_s = 1'b0;
                end
            end
            SEND_LF: begin
                if (!tx_busy) begin
                    tx_start_s = 1'b1;
                    tx_data_s  = ASCII_LF;
                end else begin
                    tx_start_s = 1'b0;
                end
            end
            default: begin
                tx_start_s = 1'b0;
                tx_data_s  = 8'h00;
            end
        endcase
    end

    assign tx_start  = tx_start_s;
    assign tx_data   = tx_data_s;
    assign buf_count = count_r;
    assign overflow  = overflow_r;
    assign draining  = draining_r;

endmodule

// File: tb/tb_uart_tx_line_buf.sv
// Directed bench for uart_tx_line_buf: a per-cycle vector table for the basic
// and empty lines, then hand sequences for full, backpressure, wrap and reset.
module tb_uart_tx_line_buf;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_rdy;
    logic       print_buf;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [5:0] buf_count;
    logic       overflow;
    logic       draining;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        logic       in_rdy;
        logic [7:0] in_data;
        logic       print_buf;
        logic       tx_busy;
        logic       exp_start;
        logic [7:0] exp_data;
        logic [5:0] exp_count;
        logic       exp_ovf;
        logic       exp_drain;
    } vec_t;

    vec_t vecs[22];

    uart_tx_line_buf #(
        .DEPTH (32),
        .AW    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .print_buf (print_buf),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .buf_count (buf_count),
        .overflow  (overflow),
        .draining  (draining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input logic pb);
        @(negedge clk);
        rst = 1'b0; in_rdy = 1'b0; in_data = 8'h00; print_buf = pb; tx_busy = 1'b0;
        #2;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic pb);
        @(negedge clk);
        rst = 1'b0; in_rdy = 1'b1; in_data = d; print_buf = pb; tx_busy = 1'b0;
        #2;
    endtask

    task automatic check_idle_state(input string tag);
        chk($sformatf("%s draining", tag), 32'(draining), 32'd0);
        chk($sformatf("%s overflow", tag), 32'(overflow), 32'd0);
        chk($sformatf("%s buf_count", tag), 32'(buf_count), 32'd0);
    endtask

    // Collects tx_start bytes after a print cycle and compares with exp_q.
    task automatic drain(input int busy_hold, input string tag);
        int cyc;
        int first_cyc;
        int last;
        int hold;
        int bad;
        bit done;
        got_q.delete();
        cyc = 0; first_cyc = -1; last = -10; hold = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            rst = 1'b0; in_rdy = 1'b0; print_buf = 1'b0;
            tx_busy = (hold > 0);
            if (hold > 0) hold--;
            #2;
            if (tx_start) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    hold = busy_hold;
                end else begin
                    chk($sformatf("%s spacing>=2", tag), 32'(cyc - last >= 2), 32'd1);
                    if (got_q.size() == 1 && busy_hold > 0)
                        chk($sformatf("%s backpressure gap", tag), 32'(cyc - first_cyc), 32'(busy_hold + 1));
                end
                got_q.push_back(tx_data);
                last = cyc;
                if (got_q.size() == exp_q.size()) done = 1'b1;
            end
            cyc++;
        end
        chk($sformatf("%s first start latency", tag), 32'(first_cyc), 32'd0);
        chk($sformatf("%s byte count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        end
        chk($sformatf("%s first bad byte index", tag), 32'(bad), 32'hFFFF_FFFF);
        idle(1'b0);
        chk($sformatf("%s draining in GAP_LF", tag), 32'(draining), 32'd1);
        idle(1'b0);
        check_idle_state(tag);
    endtask

    initial begin
        int starts;
        int late_starts;
        rst = 1'b1; in_rdy = 1'b0; in_data = 8'h00; print_buf = 1'b0; tx_busy = 1'b0;

        //            rdy   data   prt   busy  | start data  cnt  ovf   drn
        vecs[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00, 6'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 8'h00, 6'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 6'd3, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 6'd3, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd2, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h42, 6'd2, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h43, 6'd1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0D, 6'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0A, 6'd0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h0D, 6'd0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0A, 6'd0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0};

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b1;
        #2;
        chk("reset tx_start", 32'(tx_start), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        check_idle_state("reset");

        // Basic line, empty flush, drop while draining, print ignored mid-drain.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            rst = 1'b0;
            in_rdy = vecs[i].in_rdy; in_data = vecs[i].in_data;
            print_buf = vecs[i].print_buf; tx_busy = vecs[i].tx_busy;
            #2;
            chk($sformatf("vec%0d {start,data,count,ovf,drain}", i),
                32'({tx_start, tx_data, buf_count, overflow, draining}),
                32'({vecs[i].exp_start, vecs[i].exp_data, vecs[i].exp_count,
                     vecs[i].exp_ovf, vecs[i].exp_drain}));
        end

        // Full buffer: 33rd byte dropped, overflow clears after LF.
        for (int i = 0; i < 33; i++) write_byte(8'(i), 1'b0);
        idle(1'b0);
        chk("full buf_count", 32'(buf_count), 32'd32);
        chk("full overflow", 32'(overflow), 32'd1);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        idle(1'b1);
        drain(0, "full");

        // Backpressure: transmitter busy for 10 cycles after the first byte.
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            write_byte(8'h10 + 8'(i), 1'b0);
            exp_q.push_back(8'h10 + 8'(i));
        end
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        idle(1'b1);
        drain(10, "backpressure");

        // Wrap-around: 30 bytes from index 0, then 5 bytes straddling index 31.
        @(negedge clk); rst = 1'b1; in_rdy = 1'b0; print_buf = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            write_byte(8'h60 + 8'(i), 1'b0);
            exp_q.push_back(8'h60 + 8'(i));
        end
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        idle(1'b1);
        drain(0, "fill30");
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            write_byte(8'h80 + 8'(i), (i == 4));
            exp_q.push_back(8'h80 + 8'(i));
        end
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        drain(0, "wrap");

        // Reset after the second byte of a 6-byte line.
        for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i), 1'b0);
        idle(1'b1);
        starts = 0;
        for (int c = 0; c < 20 && starts < 2; c++) begin
            idle(1'b0);
            if (tx_start) starts++;
        end
        chk("middrain starts before reset", 32'(starts), 32'd2);
        @(negedge clk);
        rst = 1'b1; in_rdy = 1'b1; in_data = 8'hEE; print_buf = 1'b1; tx_busy = 1'b0;
        late_starts = 0;
        for (int c = 0; c < 8; c++) begin
            idle(1'b0);
            if (tx_start) late_starts++;
        end
        chk("middrain starts after reset", 32'(late_starts), 32'd0);
        check_idle_state("after reset");
        exp_q.delete();
        write_byte(8'hC1, 1'b0);
        write_byte(8'hC2, 1'b0);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        idle(1'b1);
        drain(0, "post-reset line");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_line_buf.md
UART_TX_LINE_BUF -- requirements
Module: uart_tx_line_buf

Interface
REQ-001 Parameter DEPTH, default 32: buffer capacity in bytes; SHALL be a power of two, 4 to 256.
REQ-002 Parameter AW, default 5: pointer width; SHALL equal log2(DEPTH).
REQ-003 Ports SHALL be as follows.
- clk  in  1: clock; all state changes on its rising edge.
- rst  in  1: reset, synchronous, active-high; clock clk.
- in_data  in  8: byte from the cipher stage.
- in_rdy  in  1: in_data is valid this cycle.
- print_buf  in  1: single-cycle pulse requesting a line flush.
- tx_busy  in  1: the UART transmitter is shifting a byte.
- tx_data  out  8: byte presented to the UART transmitter.
- tx_start  out  1: single-cycle pulse; the transmitter captures tx_data on this cycle.
- buf_count  out  AW+1: number of bytes currently stored, 0 to DEPTH.
- overflow  out  1: sticky flag; at least one byte has been dropped.
- draining  out  1: high in every state except FILL.

Function
REQ-004 The FSM SHALL have exactly these states: FILL, SEND, GAP, SEND_CR, GAP_CR, SEND_LF, GAP_LF.
REQ-005 In FILL, when in_rdy=1 and buf_count<DEPTH, the block SHALL write in_data at wr_ptr, then increment wr_ptr (modulo DEPTH) and buf_count.
REQ-006 In FILL, when in_rdy=1 and buf_count=DEPTH, the block SHALL drop the byte and set overflow.
REQ-007 In any state other than FILL, the block SHALL drop every in_rdy byte and set overflow.
REQ-008 When print_buf=1 in FILL, the next state SHALL be SEND if the post-write count is greater than 0, else SEND_CR.
REQ-009 If print_buf and in_rdy are both high in the same FILL cycle, the byte SHALL be written first and SHALL be included in the flush.
REQ-010 print_buf outside FILL SHALL be ignored.
REQ-011 In SEND, when tx_busy=0, the block SHALL:
- drive tx_start=1 for one cycle with tx_data equal to the byte at rd_ptr;
- increment rd_ptr (modulo DEPTH);
- decrement buf_count;
- go to GAP.
REQ-012 In SEND, when tx_busy=1, the block SHALL hold in SEND with tx_start=0.
REQ-013 GAP SHALL last exactly one cycle, ignoring tx_busy, so that the transmitter has time to assert busy. It SHALL then go to SEND if buf_count>0, else to SEND_CR.
REQ-014 SEND_CR and GAP_CR SHALL behave as SEND and GAP, except that tx_data=8'h0D, the buffer is untouched, and GAP_CR always goes to SEND_LF.
REQ-015 SEND_LF and GAP_LF SHALL behave likewise with tx_data=8'h0A. GAP_LF SHALL go to FILL and clear overflow.
REQ-016 Latency: tx_start SHALL first assert in the cycle after the print_buf cycle, provided tx_busy=0.
REQ-017 The spacing between consecutive tx_start pulses SHALL be at least 2 cycles.
REQ-018 tx_data SHALL be 8'h00 whenever tx_start=0.
REQ-019 Pointer wrap-around SHALL be transparent: a line that straddles the index DEPTH-1 to 0 boundary SHALL be sent in write order.
REQ-020 buf_count SHALL be registered, SHALL never exceed DEPTH, and SHALL never underflow.
REQ-021 The storage array SHALL have no reset and no read-before-write hazard, since reads occur only outside FILL.

Reset
REQ-022 On rst=1, from any state including mid-drain, the block SHALL on the next edge go to FILL and set all of the following to 0: wr_ptr, rd_ptr, buf_count, overflow, tx_start, tx_data.
REQ-023 Bytes held in the buffer at reset SHALL be discarded and never transmitted.
REQ-024 rst SHALL take priority over in_rdy and print_buf in the same cycle.

Structure
REQ-025 A shared package SHALL hold:
- the state encoding (3-bit);
- the constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
- the default DEPTH.
REQ-026 The storage SHALL be a single sub-module, line_buf_mem: DEPTH x 8, one synchronous write port and one combinational read port.
REQ-027 All control SHALL reside in uart_tx_line_buf.

Verification
REQ-028 Basic line: write 8'h41, 8'h42, 8'h43 on 3 cycles, then pulse print_buf, with tx_busy=0.
- Required: tx_start pulses carry 41, 42, 43, 0D, 0A, spaced 2 cycles apart.
- Required: draining falls the cycle after GAP_LF; buf_count reads 3, then 0.
REQ-029 Empty flush: print_buf with buf_count=0.
- Required: exactly two tx_start pulses carrying 0D, then 0A.
REQ-030 Full and overflow, with DEPTH=32: write 33 bytes 8'h00 to 8'h20.
- Required: buf_count=32 and overflow=1; byte 20 is never sent.
- Required: overflow clears after the LF is sent.
REQ-031 Backpressure: hold tx_busy=1 for 10 cycles after the first tx_start.
- Required: no further tx_start until tx_busy=0; no byte lost or duplicated.
REQ-032 Simultaneous events and wrap-around:
- Fill 30 bytes and flush them.
- Then write 5 bytes, where the 5th coincides with print_buf.
- Required: all 5 bytes (pointers wrapping at index 31) are sent in order, followed by CR and LF.
REQ-033 Reset mid-drain: assert rst after the 2nd tx_start of a 6-byte line.
- Required: no further tx_start; buf_count=0, overflow=0, draining=0.
- Required: a subsequent line is sent correctly.
